// File: rtl/srt_r2_divider.sv
// Free-running unsigned radix-2 SRT divider: samples operands every 2W+3 cycles
// and publishes floor(op1_i/op2_i) (all ones on divide by zero) on res_o.
module srt_r2_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] op1_i,
    input  logic [W-1:0] op2_i,
    output logic [W-1:0] res_o
);

    localparam int unsigned PW = W + 2;
    localparam int unsigned XW = 2 * W;
    localparam int unsigned CW = $clog2(XW);
    localparam int unsigned KW = $clog2(W);
    localparam logic signed [PW-1:0] POS_TH = PW'(2 ** (W - 1));
    localparam logic signed [PW-1:0] NEG_TH = -POS_TH;

    typedef enum logic [1:0] {LOAD, NORM, ITER, FIX} state_t;

    state_t                 state_q, state_d;
    logic [W-1:0]           a_q, a_d;
    logic [W-1:0]           b_q, b_d;
    logic                   dz_q, dz_d;
    logic [W-1:0]           d_q, d_d;
    logic [XW-1:0]          x_q, x_d;
    logic signed [PW-1:0]   p_q, p_d;
    logic [XW-1:0]          qp_q, qp_d;
    logic [XW-1:0]          qn_q, qn_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           res_q, res_d;

    logic signed [PW-1:0]   t_c;
    logic signed [PW-1:0]   dext_c;
    logic [KW-1:0]          k_c;
    logic [W-1:0]           qf_c;

    // Leading-zero count; zero input reports 0 so D stays 0 on divide by zero.
    function automatic logic [KW-1:0] lzc(input logic [W-1:0] v);
        logic [KW-1:0] n;
        logic          found;
        n     = '0;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + KW'(1);
            end
        end
        return found ? n : '0;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= LOAD;
            a_q     <= '0;
            b_q     <= '0;
            dz_q    <= 1'b0;
            d_q     <= '0;
            x_q     <= '0;
            p_q     <= '0;
            qp_q    <= '0;
            qn_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dz_q    <= dz_d;
            d_q     <= d_d;
            x_q     <= x_d;
            p_q     <= p_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dz_d    = dz_q;
        d_d     = d_q;
        x_d     = x_q;
        p_d     = p_q;
        qp_d    = qp_q;
        qn_d    = qn_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        // T = 2P + next dividend bit; range |T| < 2D always fits in PW bits.
        t_c     = $signed({p_q[PW-2:0], x_q[XW-1]});
        dext_c  = $signed({2'b00, d_q});
        k_c     = '0;
        qf_c    = '0;

        case (state_q)
            LOAD: begin
                a_d     = op1_i;
                b_d     = op2_i;
                dz_d    = (op2_i == '0);
                state_d = NORM;
            end
            NORM: begin
                k_c     = lzc(b_q);
                d_d     = b_q << k_c;
                x_d     = XW'(a_q) << k_c;
                p_d     = '0;
                qp_d    = '0;
                qn_d    = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                x_d   = x_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (t_c >= POS_TH) begin
                    p_d  = t_c - dext_c;
                    qp_d = {qp_q[XW-2:0], 1'b1};
                    qn_d = {qn_q[XW-2:0], 1'b0};
                end else if (t_c < NEG_TH) begin
                    p_d  = t_c + dext_c;
                    qp_d = {qp_q[XW-2:0], 1'b0};
                    qn_d = {qn_q[XW-2:0], 1'b1};
                end else begin
                    p_d  = t_c;
                    qp_d = {qp_q[XW-2:0], 1'b0};
                    qn_d = {qn_q[XW-2:0], 1'b0};
                end
                if (cnt_q == CW'(XW - 1)) state_d = FIX;
            end
            FIX: begin
                // Only the low W quotient bits are meaningful, so modular subtraction suffices.
                qf_c = W'(qp_q - qn_q);
                if (p_q[PW-1]) qf_c = qf_c - W'(1);
                res_d   = dz_q ? '1 : qf_c;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    assign res_o = res_q;

endmodule

// File: tb/tb_srt_r2_divider.sv
// Directed and random checks of srt_r2_divider timing and quotient values (W=8).
module tb_srt_r2_divider;

    logic       clk;
    logic       rstn;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] res;

    int n_checks = 0;
    int n_pass   = 0;

    srt_r2_divider #(.W(8)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .op1_i (op1),
        .op2_i (op2),
        .res_o (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called between a FIX edge and the next LOAD edge: drives operands, then
    // returns res_o sampled after the edge before FIX (pre) and after FIX (r).
    task automatic run_period(input logic [7:0] a, input logic [7:0] b,
                              output logic [7:0] pre, output logic [7:0] r);
        op1 = a;
        op2 = b;
        repeat (18) @(posedge clk);
        #1 pre = res;
        @(posedge clk);
        #1 r = res;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        op1  = 8'd10;
        op2  = 8'd3;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (res !== 8'd0) $display("FAIL reset_value res_o=%0d expected=0", res);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] pre, r;
        run_period(8'd10, 8'd3, pre, r);
        n_checks++;
        if (pre !== 8'd0) $display("FAIL basic_latency_pre res_o=%0d expected=0", pre);
        else n_pass++;
        n_checks++;
        if (r !== 8'd3) $display("FAIL basic_10_div_3 res_o=%0d expected=3", r);
        else n_pass++;
        run_period(8'd10, 8'd3, pre, r);
        n_checks++;
        if (pre !== 8'd3) $display("FAIL basic_hold res_o=%0d expected=3", pre);
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] va [10] = '{8'd255, 8'd255, 8'd7,   8'd200, 8'd100, 8'd100,
                                8'd0,   8'd1,   8'd254, 8'd128};
        logic [7:0] vb [10] = '{8'd1,   8'd255, 8'd200, 8'd7,   8'd0,   8'd4,
                                8'd5,   8'd1,   8'd127, 8'd128};
        logic [7:0] ve [10] = '{8'd255, 8'd1,   8'd0,   8'd28,  8'hFF,  8'd25,
                                8'd0,   8'd1,   8'd2,   8'd1};
        logic [7:0] pre, r;
        for (int i = 0; i < 10; i++) begin
            run_period(va[i], vb[i], pre, r);
            n_checks++;
            if (r !== ve[i])
                $display("FAIL directed_%0d_div_%0d res_o=%0d expected=%0d", va[i], vb[i], r, ve[i]);
            else n_pass++;
        end
    endtask

    task automatic test_change_mid();
        logic [7:0] pre, r;
        op1 = 8'd10;
        op2 = 8'd3;
        repeat (5) @(posedge clk);
        #1;
        op1 = 8'd99;
        op2 = 8'd9;
        repeat (14) @(posedge clk);
        #1;
        n_checks++;
        if (res !== 8'd3) $display("FAIL change_mid_current res_o=%0d expected=3", res);
        else n_pass++;
        run_period(8'd99, 8'd9, pre, r);
        n_checks++;
        if (r !== 8'd11) $display("FAIL change_mid_next res_o=%0d expected=11", r);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] pre, r;
        op1 = 8'd200;
        op2 = 8'd7;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (res !== 8'd0) $display("FAIL reset_mid_clear res_o=%0d expected=0", res);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        run_period(8'd200, 8'd7, pre, r);
        n_checks++;
        if (pre !== 8'd0) $display("FAIL reset_mid_pre res_o=%0d expected=0", pre);
        else n_pass++;
        n_checks++;
        if (r !== 8'd28) $display("FAIL reset_mid_restart res_o=%0d expected=28", r);
        else n_pass++;
    endtask

    task automatic test_random_sweep();
        logic [7:0] a, b, exp_q, pre, r;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 25 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            exp_q = (b == 8'd0) ? 8'hFF : 8'(a / b);
            run_period(a, b, pre, r);
            n_checks++;
            if (r !== exp_q)
                $display("FAIL random_%0d_div_%0d res_o=%0d expected=%0d", a, b, r, exp_q);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_directed();
        test_change_mid();
        test_reset_mid();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
